// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
// Constants and types shared by the pipelined processor's memory-side logic.
//   ADDR_W      : default address width of the unified memory
//   DATA_W      : default data width of the unified memory
//   arb_state_e : state of the fetch/data memory port arbiter
// ---------------------------------------------------------------------------
package proc_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_DM = 2'd2
  } arb_state_e;

endpackage : proc_pkg

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported unified memory between the fetch stage (IF) and
// the memory stage (MEM). One transaction is outstanding at a time; each
// response is steered back to the requester that owns it. MEM has priority,
// but after MAX_DM_STREAK consecutive MEM grants while IF is waiting, IF is
// given the next slot. A fetch cancelled by if_flush still has its response
// consumed, but the response is not forwarded.
//
// Ports
//   clk, reset                 : clock, asynchronous active-high reset
//   if_req/if_addr/if_flush    : fetch request, address, cancel
//   if_gnt/if_rvalid/if_rdata  : fetch accept, fetch data valid, fetch data
//   dm_req/dm_we/dm_be/
//   dm_addr/dm_wdata           : data request (load/store) and payload
//   dm_gnt/dm_rvalid/dm_rdata  : data accept, load data / store done, data
//   mem_req/mem_we/mem_be/
//   mem_addr/mem_wdata         : request channel to the memory
//   mem_ready                  : memory accepts when mem_req & mem_ready
//   mem_rvalid/mem_rdata       : one response per accepted request
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W        = proc_pkg::ADDR_W,
  parameter int DATA_W        = proc_pkg::DATA_W,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  // fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  // data port
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  // memory port
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  import proc_pkg::*;

  localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

  arb_state_e          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                drop_q, drop_d;

  logic in_idle;
  logic if_elig;
  logic if_forced;
  logic sel_if;
  logic sel_dm;
  logic accept;

  // Reset gates the request channel so every output reads 0 while it is held,
  // even though the state register is already IDLE.
  assign in_idle = (state_q == IDLE) & ~reset;

  // A flushed fetch is never presented to memory.
  assign if_elig = if_req & ~if_flush;

  // IF overrides MEM only once MEM has used up its streak while IF waited.
  assign if_forced = (streak_q == STREAK_MAX) & if_elig;
  assign sel_dm    = dm_req & ~if_forced;
  assign sel_if    = if_elig & ~sel_dm;

  assign mem_req = in_idle & (sel_if | sel_dm);
  assign accept  = mem_req & mem_ready;
  assign if_gnt  = accept & sel_if;
  assign dm_gnt  = accept & sel_dm;

  // Payload is zero whenever no request is presented; fetches are reads with
  // no byte enables.
  assign mem_we    = mem_req & sel_dm & dm_we;
  assign mem_be    = (mem_req & sel_dm) ? dm_be    : '0;
  assign mem_wdata = (mem_req & sel_dm) ? dm_wdata : '0;
  always_comb begin
    mem_addr = '0;
    if (mem_req) begin
      mem_addr = sel_dm ? dm_addr : if_addr;
    end
  end

  // Responses go only to the owner of the outstanding transaction. A fetch
  // flushed earlier (drop_q) or in the response cycle itself is suppressed.
  assign if_rvalid = mem_rvalid & (state_q == WAIT_IF) & ~drop_q & ~if_flush & ~reset;
  assign dm_rvalid = mem_rvalid & (state_q == WAIT_DM) & ~reset;
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (if_gnt) begin
          state_d = WAIT_IF;
        end else if (dm_gnt) begin
          state_d = WAIT_DM;
        end
      end
      WAIT_IF: begin
        if (mem_rvalid) begin
          state_d = IDLE;
        end
      end
      WAIT_DM: begin
        if (mem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // drop remembers a flush seen while the fetch is in flight and is cleared
  // as soon as that fetch's response is consumed.
  always_comb begin
    drop_d = 1'b0;
    if ((state_q == WAIT_IF) && !mem_rvalid) begin
      drop_d = drop_q | if_flush;
    end
  end

  // The streak counts MEM grants taken while IF was asking; it only matters
  // while IF is waiting, so it resets whenever IF stops asking or is served.
  always_comb begin
    streak_d = streak_q;
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (dm_gnt && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + STREAK_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      streak_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      drop_q   <= drop_d;
    end
  end

endmodule : mem_port_arbiter
